// File: rtl/jt12_pcm_feed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jt12_pcm_feed
//  Purpose  : YM2612 DAC front-end. Captures CPU writes to the DAC data
//             register (0x2A) and DAC enable register (0x2B), buffers the
//             samples in a small FIFO and releases one sample every second
//             rising edge of `zero` as a signed 9-bit value with a strobe.
//  Ports    : clk, rst (sync, active high), clk_en (advance enable)
//             din[7:0], dac_wr (0x2A strobe), en_wr (0x2B strobe, din[7])
//             zero (slot marker)
//             pcm[8:0], pcm_wr (1-clk strobe), dacen, fill[AW:0], ovf, udf
//  Options  : `JT12_PCM_DITHER_EN -- adds an 8-bit LFSR that drives the pcm LSB
//  Revision : 1.0 -- initial release
// ============================================================================
module jt12_pcm_feed #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic [7:0]    din,
    input  logic          dac_wr,
    input  logic          en_wr,
    input  logic          zero,
    output logic [8:0]    pcm,
    output logic          pcm_wr,
    output logic          dacen,
    output logic [AW:0]   fill,
    output logic          ovf,
    output logic          udf
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    // Registered state
    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        zero_q,   zero_d;
    logic        ph_q,     ph_d;
    logic        dacen_q,  dacen_d;
    logic        ovf_q,    ovf_d;
    logic        udf_q,    udf_d;
    logic [8:0]  pcm_q,    pcm_d;
    logic        pcm_wr_q, pcm_wr_d;

    // Combinational helpers
    logic          w_edge;
    logic          w_pop_slot;
    logic          w_dacen_eff;
    logic [AW:0]   w_rd_base;
    logic [AW:0]   w_fill_eff;
    logic [AW:0]   w_wr_prev;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic [7:0]    w_head;
    logic          w_lsb;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;

`ifdef JT12_PCM_DITHER_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign w_lsb = lfsr_q[0];
`else
    assign w_lsb = 1'b0;
`endif

    always_comb begin
        // An enable write is applied before anything else in the same cycle,
        // so pops and pushes are judged against the new enable, and a flush
        // (rd := wr) empties the FIFO before any pop is considered.
        w_edge      = zero & ~zero_q;
        w_pop_slot  = w_edge & ph_q;
        w_dacen_eff = en_wr ? din[7] : dacen_q;
        w_rd_base   = (en_wr & ~din[7]) ? wr_ptr_q : rd_ptr_q;
        w_fill_eff  = wr_ptr_q - w_rd_base;
        w_wr_prev   = wr_ptr_q - C_ONE;
        w_empty     = (w_fill_eff == '0);
        w_full      = (w_fill_eff == C_DEPTH);
        w_pop       = w_pop_slot & w_dacen_eff & ~w_empty;
        w_head      = mem_q[w_rd_base[AW-1:0]];

        zero_d     = zero_q;
        ph_d       = ph_q;
        dacen_d    = dacen_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        pcm_d      = pcm_q;
        pcm_wr_d   = 1'b0;          // strobe always self-clears, even with clk_en low
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        w_mem_we   = 1'b0;
        w_mem_addr = wr_ptr_q[AW-1:0];
`ifdef JT12_PCM_DITHER_EN
        lfsr_d     = lfsr_q;
`endif

        if (clk_en) begin
            zero_d = zero;
            if (w_edge) begin
                ph_d = ~ph_q;
            end

            if (en_wr) begin
                dacen_d = din[7];
                ovf_d   = 1'b0;
                udf_d   = 1'b0;
                if (!din[7]) begin
                    rd_ptr_d = wr_ptr_q;
                    pcm_d    = '0;
                end
            end

            // Every pop slot strobes so the downstream cadence never stalls.
            if (w_pop_slot) begin
                pcm_wr_d = 1'b1;
                if (!w_dacen_eff) begin
                    pcm_d = '0;
                end else if (w_empty) begin
                    udf_d = 1'b1;
                end else begin
                    pcm_d    = {~w_head[7], w_head[6:0], w_lsb};
                    rd_ptr_d = w_rd_base + C_ONE;
`ifdef JT12_PCM_DITHER_EN
                    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                end
            end

            // Full without a pop: the newest entry is replaced so the latest
            // CPU sample is the one that eventually plays.
            if (dac_wr & w_dacen_eff) begin
                w_mem_we = 1'b1;
                if (w_full & ~w_pop) begin
                    w_mem_addr = w_wr_prev[AW-1:0];
                    ovf_d      = 1'b1;
                end else begin
                    w_mem_addr = wr_ptr_q[AW-1:0];
                    wr_ptr_d   = wr_ptr_q + C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            zero_q   <= 1'b0;
            ph_q     <= 1'b0;
            dacen_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            pcm_q    <= '0;
            pcm_wr_q <= 1'b0;
`ifdef JT12_PCM_DITHER_EN
            lfsr_q   <= 8'h01;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            zero_q   <= zero_d;
            ph_q     <= ph_d;
            dacen_q  <= dacen_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            pcm_q    <= pcm_d;
            pcm_wr_q <= pcm_wr_d;
`ifdef JT12_PCM_DITHER_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    // Storage needs no reset: pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            mem_q[w_mem_addr] <= din;
        end
    end

    assign pcm    = pcm_q;
    assign pcm_wr = pcm_wr_q;
    assign dacen  = dacen_q;
    assign fill   = wr_ptr_q - rd_ptr_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_pcm_feed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_jt12_pcm_feed
//  Purpose  : Self-checking bench for jt12_pcm_feed; directed scenarios plus
//             a randomized run against a queue-based reference model.
//  Revision : 1.0 -- initial release
// ============================================================================
module tb_jt12_pcm_feed;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, clk_en, dac_wr, en_wr, zero;
    logic [7:0]  din;
    logic [8:0]  pcm;
    logic        pcm_wr, dacen, ovf, udf;
    logic [AW:0] fill;

    int vectors     = 0;
    int miscompares = 0;

    jt12_pcm_feed #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .din(din), .dac_wr(dac_wr),
        .en_wr(en_wr), .zero(zero), .pcm(pcm), .pcm_wr(pcm_wr),
        .dacen(dacen), .fill(fill), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    logic       m_zero, m_ph, m_dacen, m_ovf, m_udf, m_pcm_wr;
    logic [8:0] m_pcm;
    logic [7:0] m_lfsr;

    // Unsigned byte recentred around zero, scaled by two, plus LSB.
    function automatic logic [8:0] to_pcm(input logic [7:0] b, input logic lsb);
        int v;
        v = (int'(b) - 128) * 2 + int'(lsb);
        return v[8:0];
    endfunction

    function automatic void model_step();
        logic zedge, slot, lsb;
        logic [7:0] b;
        m_pcm_wr = 1'b0;
        if (rst) begin
            m_q.delete();
            m_zero = 0; m_ph = 0; m_dacen = 0; m_ovf = 0; m_udf = 0;
            m_pcm = '0; m_lfsr = 8'h01;
            return;
        end
        if (!clk_en) return;
        zedge  = zero && !m_zero;
        m_zero = zero;
        slot   = zedge && m_ph;
        if (zedge) m_ph = !m_ph;
        if (en_wr) begin
            m_dacen = din[7]; m_ovf = 0; m_udf = 0;
            if (!din[7]) begin m_q.delete(); m_pcm = '0; end
        end
        if (slot) begin
            m_pcm_wr = 1'b1;
            if (!m_dacen) m_pcm = '0;
            else if (m_q.size() == 0) m_udf = 1'b1;
            else begin
                b = m_q.pop_front();
`ifdef JT12_PCM_DITHER_EN
                lsb    = m_lfsr[0];
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
                lsb = 1'b0;
`endif
                m_pcm = to_pcm(b, lsb);
            end
        end
        if (dac_wr && m_dacen) begin
            if (m_q.size() == DEPTH) begin m_q[m_q.size()-1] = din; m_ovf = 1'b1; end
            else m_q.push_back(din);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        din = b; dac_wr = 1'b1; tick(); dac_wr = 1'b0;
    endtask

    task automatic enable(input logic [7:0] b);
        din = b; en_wr = 1'b1; tick(); en_wr = 1'b0;
    endtask

    task automatic zero_lo();
        zero = 1'b0; tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++; if (pcm !== 9'h000) begin miscompares++; $display("FAIL reset_pcm got=%h exp=000", pcm); end
        vectors++; if (pcm_wr !== 1'b0) begin miscompares++; $display("FAIL reset_pcm_wr got=%b exp=0", pcm_wr); end
        vectors++; if (dacen !== 1'b0) begin miscompares++; $display("FAIL reset_dacen got=%b exp=0", dacen); end
        vectors++; if (fill !== 3'd0) begin miscompares++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        vectors++; if (udf !== 1'b0) begin miscompares++; $display("FAIL reset_udf got=%b exp=0", udf); end
    endtask

    task automatic test_basic();
        enable(8'h80);
        write_byte(8'hFF);
        vectors++; if (fill !== 3'd1) begin miscompares++; $display("FAIL basic_fill1 got=%0d exp=1", fill); end
        zero = 1'b1; tick();
        vectors++; if (pcm_wr !== 1'b0) begin miscompares++; $display("FAIL basic_edge1_wr got=%b exp=0", pcm_wr); end
        zero_lo();
        zero = 1'b1; tick();
        vectors++; if (pcm_wr !== 1'b1) begin miscompares++; $display("FAIL basic_edge2_wr got=%b exp=1", pcm_wr); end
        vectors++; if ((pcm & 9'h1FE) !== 9'h0FE) begin miscompares++; $display("FAIL basic_pcm got=%h exp=0FE", pcm); end
        vectors++; if (pcm !== m_pcm) begin miscompares++; $display("FAIL basic_pcm_model got=%h exp=%h", pcm, m_pcm); end
        vectors++; if (fill !== 3'd0) begin miscompares++; $display("FAIL basic_fill0 got=%0d exp=0", fill); end
        zero_lo();
        vectors++; if (pcm_wr !== 1'b0) begin miscompares++; $display("FAIL basic_wr_width got=%b exp=0", pcm_wr); end
    endtask

    task automatic test_order();
        logic [8:0] exp_p [3];
        logic       exp_wr;
        int         idx;
        exp_p = '{9'h100, 9'h180, 9'h080};
        write_byte(8'h00); write_byte(8'h40); write_byte(8'hC0);
        for (int k = 1; k <= 8; k++) begin
            zero = 1'b1; tick();
            exp_wr = (k % 2 == 0);
            vectors++; if (pcm_wr !== exp_wr) begin miscompares++; $display("FAIL order_wr edge=%0d got=%b exp=%b", k, pcm_wr, exp_wr); end
            if (exp_wr) begin
                idx = (k / 2 <= 3) ? k / 2 - 1 : 2;
                vectors++; if ((pcm & 9'h1FE) !== exp_p[idx]) begin miscompares++; $display("FAIL order_pcm pop=%0d got=%h exp=%h", k / 2, pcm, exp_p[idx]); end
                if (k == 8) begin
                    vectors++; if (udf !== 1'b1) begin miscompares++; $display("FAIL order_udf got=%b exp=1", udf); end
                end
            end
            zero_lo();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [4];
        logic [8:0] exp_pcm;
        exp_b = '{8'd1, 8'd2, 8'd3, 8'd5};
        enable(8'h80);
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        vectors++; if (fill !== 3'd4) begin miscompares++; $display("FAIL ovf_fill got=%0d exp=4", fill); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        for (int k = 1; k <= 8; k++) begin
            zero = 1'b1; tick();
            if (k % 2 == 0) begin
                exp_pcm = to_pcm(exp_b[k/2-1], 1'b0);
                vectors++; if ((pcm & 9'h1FE) !== exp_pcm) begin miscompares++; $display("FAIL ovf_pop%0d got=%h exp=%h", k / 2, pcm, exp_pcm); end
            end
            zero_lo();
        end
    endtask

    task automatic test_disable();
        enable(8'h80);
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        enable(8'h00);
        vectors++; if (fill !== 3'd0) begin miscompares++; $display("FAIL dis_fill got=%0d exp=0", fill); end
        vectors++; if (pcm !== 9'h000) begin miscompares++; $display("FAIL dis_pcm got=%h exp=000", pcm); end
        vectors++; if (dacen !== 1'b0) begin miscompares++; $display("FAIL dis_dacen got=%b exp=0", dacen); end
        write_byte(8'h55);
        vectors++; if (fill !== 3'd0) begin miscompares++; $display("FAIL dis_write_ignored got=%0d exp=0", fill); end
        for (int k = 1; k <= 4; k++) begin
            zero = 1'b1; tick();
            if (k % 2 == 0) begin
                vectors++; if (pcm_wr !== 1'b1) begin miscompares++; $display("FAIL dis_wr edge=%0d got=%b exp=1", k, pcm_wr); end
                vectors++; if (pcm !== 9'h000) begin miscompares++; $display("FAIL dis_pcm0 got=%h exp=000", pcm); end
                vectors++; if (udf !== 1'b0) begin miscompares++; $display("FAIL dis_udf got=%b exp=0", udf); end
            end
            zero_lo();
        end
    endtask

    task automatic test_simultaneous();
        enable(8'h80);
        for (int i = 0; i < 4; i++) write_byte(8'($urandom_range(0, 255)));
        zero = 1'b1; tick(); zero_lo();
        zero = 1'b1; din = 8'hA5; dac_wr = 1'b1; tick(); dac_wr = 1'b0;
        vectors++; if (pcm_wr !== 1'b1) begin miscompares++; $display("FAIL sim_full_wr got=%b exp=1", pcm_wr); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sim_full_ovf got=%b exp=0", ovf); end
        vectors++; if (fill !== 3'd4) begin miscompares++; $display("FAIL sim_full_fill got=%0d exp=4", fill); end
        vectors++; if (pcm !== m_pcm) begin miscompares++; $display("FAIL sim_full_pcm got=%h exp=%h", pcm, m_pcm); end
        zero_lo();
        for (int k = 0; k < 8; k++) begin zero = 1'b1; tick(); zero_lo(); end
        vectors++; if (fill !== 3'd0) begin miscompares++; $display("FAIL sim_drain got=%0d exp=0", fill); end
        zero = 1'b1; tick(); zero_lo();
        zero = 1'b1; din = 8'h3C; dac_wr = 1'b1; tick(); dac_wr = 1'b0;
        vectors++; if (udf !== 1'b1) begin miscompares++; $display("FAIL sim_empty_udf got=%b exp=1", udf); end
        vectors++; if (fill !== 3'd1) begin miscompares++; $display("FAIL sim_empty_fill got=%0d exp=1", fill); end
        vectors++; if (pcm !== m_pcm) begin miscompares++; $display("FAIL sim_empty_hold got=%h exp=%h", pcm, m_pcm); end
        zero_lo();
    endtask

    task automatic test_reset_clk_en();
        write_byte(8'h66);
        zero = 1'b1; tick(); zero_lo();
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++; if ({pcm, pcm_wr, dacen, fill, ovf, udf} !== '0) begin miscompares++;
            $display("FAIL midrst_outputs got pcm=%h wr=%b en=%b fill=%0d ovf=%b udf=%b exp all 0", pcm, pcm_wr, dacen, fill, ovf, udf); end
        enable(8'h80);
        write_byte(8'h77);
        zero = 1'b1; tick();
        vectors++; if (pcm_wr !== 1'b0) begin miscompares++; $display("FAIL midrst_edge1 got=%b exp=0", pcm_wr); end
        zero_lo();
        zero = 1'b1; tick();
        vectors++; if (pcm_wr !== 1'b1) begin miscompares++; $display("FAIL midrst_edge2 got=%b exp=1", pcm_wr); end
        vectors++; if ((pcm & 9'h1FE) !== to_pcm(8'h77, 1'b0)) begin miscompares++; $display("FAIL midrst_pcm got=%h exp=%h", pcm, to_pcm(8'h77, 1'b0)); end
        zero_lo();
        // clock enable held low: edges, writes and enable writes are ignored
        clk_en = 1'b0;
        zero = 1'b1; din = 8'h12; dac_wr = 1'b1; tick();
        vectors++; if (fill !== 3'd0) begin miscompares++; $display("FAIL cen_fill got=%0d exp=0", fill); end
        zero = 1'b0; tick(); zero = 1'b1; tick();
        dac_wr = 1'b0; din = 8'h00; en_wr = 1'b1; tick(); en_wr = 1'b0;
        vectors++; if (pcm_wr !== 1'b0) begin miscompares++; $display("FAIL cen_wr got=%b exp=0", pcm_wr); end
        vectors++; if (dacen !== 1'b1) begin miscompares++; $display("FAIL cen_dacen got=%b exp=1", dacen); end
        zero = 1'b0; clk_en = 1'b1; tick();
        zero = 1'b1; tick(); zero_lo();
        zero = 1'b1; tick();
        vectors++; if (pcm_wr !== 1'b1) begin miscompares++; $display("FAIL cen_pop got=%b exp=1", pcm_wr); end
        clk_en = 1'b0; zero = 1'b0; tick();
        vectors++; if (pcm_wr !== 1'b0) begin miscompares++; $display("FAIL cen_strobe_clear got=%b exp=0", pcm_wr); end
        clk_en = 1'b1; tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 149) == 0);
            clk_en = ($urandom_range(0, 3) != 0);
            zero   = $urandom_range(0, 1) == 1;
            dac_wr = ($urandom_range(0, 2) == 0);
            en_wr  = ($urandom_range(0, 19) == 0);
            din    = 8'($urandom_range(0, 255));
            if (en_wr && $urandom_range(0, 3) != 0) din[7] = 1'b1;
            tick();
            vectors++; if (pcm !== m_pcm) begin miscompares++; $display("FAIL rnd_pcm n=%0d got=%h exp=%h", n, pcm, m_pcm); end
            vectors++; if (pcm_wr !== m_pcm_wr) begin miscompares++; $display("FAIL rnd_pcm_wr n=%0d got=%b exp=%b", n, pcm_wr, m_pcm_wr); end
            vectors++; if (dacen !== m_dacen) begin miscompares++; $display("FAIL rnd_dacen n=%0d got=%b exp=%b", n, dacen, m_dacen); end
            vectors++; if (fill !== (AW+1)'(m_q.size())) begin miscompares++; $display("FAIL rnd_fill n=%0d got=%0d exp=%0d", n, fill, m_q.size()); end
            vectors++; if (ovf !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, ovf, m_ovf); end
            vectors++; if (udf !== m_udf) begin miscompares++; $display("FAIL rnd_udf n=%0d got=%b exp=%b", n, udf, m_udf); end
        end
        rst = 1'b0; clk_en = 1'b1; dac_wr = 1'b0; en_wr = 1'b0; zero = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; dac_wr = 1'b0; en_wr = 1'b0; zero = 1'b0; din = 8'h00;
        test_reset();
        test_basic();
        test_order();
        test_overflow();
        test_disable();
        test_simultaneous();
        test_reset_clk_en();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
